// File: rtl/uart_rx_fifo.sv
// UART receive buffer: drains characters from the receive engine
// into a first-word-fall-through FIFO presented to the processor bus.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int THRESH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic [7:0]    rx_status,
  output logic          rx_reads,
  input  logic          cpu_read,
  input  logic          clr_ovf,
  output logic [7:0]    cpu_data,
  output logic [7:0]    cpu_status,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          fifo_ovf,
  output logic          rx_int
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    WAITC = 2'd2
  } state_t;

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   THRESH_C = (AW+1)'(THRESH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t        state_q, state_d;
  logic          reads_q, reads_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [10:0]   mem_q [DEPTH];

  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;
  logic [10:0]   entry;
  logic [10:0]   head;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  assign push_req = (state_q == CAPT);
  assign pop      = cpu_read & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign entry = {rx_status[4], rx_status[3], rx_status[2], rx_data};
  assign head  = mem_q[rptr_q];

  // Drain FSM next state; rx_reads is high exactly while in CAPT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rx_status[0]) state_d = CAPT;
      CAPT:    state_d = WAITC;
      WAITC:   if (!rx_status[0]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    reads_d = (state_d == CAPT);
  end

  // Pointer, count and sticky overflow next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      reads_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      reads_q <= reads_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= entry;
  end

  assign rx_reads = reads_q;
  assign count    = count_q;
  assign fifo_ovf = ovf_q;
  assign rx_int   = (count_q >= THRESH_C);

  assign cpu_data   = empty ? 8'h00 : head[7:0];
  assign cpu_status = empty ? 8'h00
                    : {3'b000, head[10], head[9], head[8], 1'b0, 1'b1};

endmodule
